// File: rtl/score_keeper_if.sv
// Score keeper bus: game control inputs and the registered score/status outputs.
interface score_keeper_if #(
   parameter int DIGITS    = 2,
   parameter int MAX_SCORE = 10
);
   localparam int SW = $clog2(MAX_SCORE + 1);

   logic                  reached_target;
   logic                  game_start;
   logic                  game_over;
   logic [SW-1:0]         score_bin;
   logic [4*DIGITS-1:0]   score_bcd;
   logic [4*DIGITS-1:0]   high_bcd;
   logic [3:0]            level;
   logic                  level_up;
   logic                  new_high;
   logic                  max_reached;
   logic                  busy;

   modport master (
      output reached_target, game_start, game_over,
      input  score_bin, score_bcd, high_bcd, level, level_up,
             new_high, max_reached, busy
   );

   modport slave (
      input  reached_target, game_start, game_over,
      output score_bin, score_bcd, high_bcd, level, level_up,
             new_high, max_reached, busy
   );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: credits points for target events one per clock, tracks a BCD
// score alongside the binary one, a high score, and a level derived from score.
module score_keeper #(
   parameter int DIGITS     = 2,
   parameter int MAX_SCORE  = 10,
   parameter int POINTS     = 1,
   parameter int LEVEL_STEP = 5,
   parameter int PEND_W     = 4
) (
   input  logic           clk,
   input  logic           rst,
   score_keeper_if.slave  bus
);
   localparam int SW = $clog2(MAX_SCORE + 1);
   localparam int BW = 4 * DIGITS;
   localparam int LW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

   typedef enum logic [1:0] {PLAY, ADD, OVER} state_t;

   state_t              state, state_nxt;
   logic                prev;
   logic [PEND_W-1:0]   pending, pending_nxt;
   logic [SW-1:0]       score, score_nxt;
   logic [BW-1:0]       bcd, bcd_nxt;
   logic [BW-1:0]       high, high_nxt;
   logic [3:0]          level, level_nxt;
   logic [LW-1:0]       lvl_cnt, lvl_cnt_nxt;
   logic                level_up, level_up_nxt;
   logic                new_high, new_high_nxt;
   logic                max_reached, max_nxt;
   logic                busy, busy_nxt;
   logic                evt;

   // BCD +1 with ripple carry from digit 0 upward.
   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Clamp a pending-points value to the counter's range.
   function automatic logic [PEND_W-1:0] pend_sat(input int v);
      if (v > (1 << PEND_W) - 1) return '1;
      return PEND_W'(v);
   endfunction

   // State and output registers; reset clears everything including the high score.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= PLAY;
         prev        <= 1'b0;
         pending     <= '0;
         score       <= '0;
         bcd         <= '0;
         high        <= '0;
         level       <= '0;
         lvl_cnt     <= '0;
         level_up    <= 1'b0;
         new_high    <= 1'b0;
         max_reached <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         prev        <= bus.reached_target;
         pending     <= pending_nxt;
         score       <= score_nxt;
         bcd         <= bcd_nxt;
         high        <= high_nxt;
         level       <= level_nxt;
         lvl_cnt     <= lvl_cnt_nxt;
         level_up    <= level_up_nxt;
         new_high    <= new_high_nxt;
         max_reached <= max_nxt;
         busy        <= busy_nxt;
      end
   end

   // Next state: start beats over beats event; ADD credits one point per clock.
   always_comb begin
      state_nxt    = state;
      pending_nxt  = pending;
      score_nxt    = score;
      bcd_nxt      = bcd;
      high_nxt     = high;
      level_nxt    = level;
      lvl_cnt_nxt  = lvl_cnt;
      level_up_nxt = 1'b0;
      new_high_nxt = new_high;
      max_nxt      = max_reached;
      evt          = bus.reached_target & ~prev;

      if (bus.game_start) begin
         state_nxt   = PLAY;
         pending_nxt = '0;
         score_nxt   = '0;
         bcd_nxt     = '0;
         level_nxt   = '0;
         lvl_cnt_nxt = '0;
         new_high_nxt = 1'b0;
         max_nxt     = 1'b0;
      end else if (bus.game_over && state != OVER) begin
         state_nxt   = OVER;
         pending_nxt = '0;
      end else begin
         case (state)
            PLAY: begin
               if (evt) begin
                  pending_nxt = pend_sat(POINTS);
                  state_nxt   = ADD;
               end
            end
            ADD: begin
               score_nxt = score + SW'(1);
               bcd_nxt   = bcd_inc(bcd);
               // BCD ordering matches numeric ordering, so compare directly.
               if (bcd_nxt > high) begin
                  high_nxt     = bcd_nxt;
                  new_high_nxt = 1'b1;
               end
               if (lvl_cnt == LW'(LEVEL_STEP - 1)) begin
                  lvl_cnt_nxt = '0;
                  if (level != 4'd15) begin
                     level_nxt    = level + 4'd1;
                     level_up_nxt = 1'b1;
                  end
               end else begin
                  lvl_cnt_nxt = lvl_cnt + LW'(1);
               end
               if (score_nxt == SW'(MAX_SCORE)) begin
                  pending_nxt = '0;
                  max_nxt     = 1'b1;
                  state_nxt   = OVER;
               end else if (evt) begin
                  pending_nxt = pend_sat(int'(pending) - 1 + POINTS);
               end else begin
                  pending_nxt = pending - PEND_W'(1);
                  if (pending == PEND_W'(1)) state_nxt = PLAY;
               end
            end
            OVER: begin
               state_nxt = OVER;
            end
            default: begin
               state_nxt = PLAY;
            end
         endcase
      end
      busy_nxt = (state_nxt == ADD);
   end

   assign bus.score_bin   = score;
   assign bus.score_bcd   = bcd;
   assign bus.high_bcd    = high;
   assign bus.level       = level;
   assign bus.level_up    = level_up;
   assign bus.new_high    = new_high;
   assign bus.max_reached = max_reached;
   assign bus.busy        = busy;
endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: directed scenarios plus random play against a
// count-based reference model.
module tb_score_keeper;
   localparam int DIGITS     = 2;
   localparam int MAX_SCORE  = 10;
   localparam int POINTS     = 1;
   localparam int LEVEL_STEP = 5;
   localparam int PEND_W     = 4;
   localparam int PMAX       = (1 << PEND_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   score_keeper_if #(.DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE)) bus ();
   score_keeper_if #(.DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE)) bus3 ();

   score_keeper #(.DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE), .POINTS(POINTS),
                  .LEVEL_STEP(LEVEL_STEP), .PEND_W(PEND_W))
      dut (.clk(clk), .rst(rst), .bus(bus));

   score_keeper #(.DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE), .POINTS(3),
                  .LEVEL_STEP(LEVEL_STEP), .PEND_W(PEND_W))
      dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int n_checks = 0;
   int n_errors = 0;
   int lu_seen  = 0;

   // reference model: score, points still owed, game-over flag, high score
   int m_score, m_pend, m_high, m_prev;
   bit m_over, m_nh, m_maxr, m_lu;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int to_bcd(input int v);
      return ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   function automatic int lvl(input int s);
      return (s / LEVEL_STEP > 15) ? 15 : s / LEVEL_STEP;
   endfunction

   task automatic model_reset();
      m_score = 0; m_pend = 0; m_high = 0; m_prev = 0;
      m_over = 0; m_nh = 0; m_maxr = 0; m_lu = 0;
   endtask

   task automatic model_step();
      bit evt;
      m_lu = 0;
      if (rst) begin
         model_reset();
         return;
      end
      evt    = bus.reached_target && (m_prev == 0);
      m_prev = int'(bus.reached_target);
      if (bus.game_start) begin
         m_score = 0; m_pend = 0; m_over = 0; m_nh = 0; m_maxr = 0;
      end else if (bus.game_over && !m_over) begin
         m_over = 1; m_pend = 0;
      end else if (!m_over) begin
         if (m_pend == 0) begin
            if (evt) m_pend = (POINTS > PMAX) ? PMAX : POINTS;
         end else begin
            m_score++;
            if (m_score > m_high) begin
               m_high = m_score;
               m_nh   = 1;
            end
            m_lu = (lvl(m_score) != lvl(m_score - 1));
            if (m_score == MAX_SCORE) begin
               m_pend = 0; m_maxr = 1; m_over = 1;
            end else if (evt) begin
               m_pend = (m_pend - 1 + POINTS > PMAX) ? PMAX : m_pend - 1 + POINTS;
            end else begin
               m_pend--;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("score_bin", 32'(bus.score_bin), m_score);
      chk("score_bcd", 32'(bus.score_bcd), to_bcd(m_score));
      chk("high_bcd", 32'(bus.high_bcd), to_bcd(m_high));
      chk("level", 32'(bus.level), lvl(m_score));
      chk("level_up", 32'(bus.level_up), 32'(m_lu));
      chk("new_high", 32'(bus.new_high), 32'(m_nh));
      chk("max_reached", 32'(bus.max_reached), 32'(m_maxr));
      chk("busy", 32'(bus.busy), 32'(!m_over && m_pend > 0));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      lu_seen += int'(bus.level_up);
   endtask

   task automatic event_pulse(input int gap);
      bus.reached_target = 1'b1;
      cycle();
      bus.reached_target = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic start_pulse();
      bus.game_start = 1'b1;
      cycle();
      bus.game_start = 1'b0;
   endtask

   int busy_cnt;

   initial begin
      rst = 1'b1;
      bus.reached_target = 1'b0; bus.game_start = 1'b0; bus.game_over = 1'b0;
      bus3.reached_target = 1'b0; bus3.game_start = 1'b0; bus3.game_over = 1'b0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // single one-cycle event
      bus.reached_target = 1'b1;
      cycle();
      chk("pulse_busy", 32'(bus.busy), 1);
      chk("pulse_score_hold", 32'(bus.score_bin), 0);
      bus.reached_target = 1'b0;
      cycle();
      chk("pulse_score", 32'(bus.score_bin), 1);
      chk("pulse_bcd", 32'(bus.score_bcd), 32'h01);
      chk("pulse_new_high", 32'(bus.new_high), 1);
      chk("pulse_busy_end", 32'(bus.busy), 0);

      // level held high for 20 cycles is one event
      bus.reached_target = 1'b1;
      repeat (20) cycle();
      bus.reached_target = 1'b0;
      cycle();
      chk("held_one_point", 32'(bus.score_bin), 2);

      // ten events reach the cap
      start_pulse();
      lu_seen = 0;
      repeat (10) event_pulse(2);
      chk("max_bcd", 32'(bus.score_bcd), 32'h10);
      chk("max_flag", 32'(bus.max_reached), 1);
      chk("max_level", 32'(bus.level), 2);
      chk("level_up_count", lu_seen, 2);
      event_pulse(2);
      chk("over_ignores", 32'(bus.score_bin), 10);
      chk("over_not_busy", 32'(bus.busy), 0);

      // high score kept across a restart
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (7) event_pulse(1);
      chk("score7", 32'(bus.score_bin), 7);
      start_pulse();
      chk("restart_score", 32'(bus.score_bin), 0);
      chk("restart_high", 32'(bus.high_bcd), 32'h07);
      repeat (3) event_pulse(1);
      chk("below_high_nh", 32'(bus.new_high), 0);
      chk("below_high_keep", 32'(bus.high_bcd), 32'h07);
      chk("below_high_score", 32'(bus.score_bin), 3);

      // start and over together: start wins
      bus.game_start = 1'b1; bus.game_over = 1'b1;
      cycle();
      bus.game_start = 1'b0; bus.game_over = 1'b0;
      bus.reached_target = 1'b1;
      cycle();
      bus.reached_target = 1'b0;
      chk("start_wins_busy", 32'(bus.busy), 1);
      // asynchronous reset mid-ADD, between clock edges
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      chk("async_rst_busy", 32'(bus.busy), 0);
      chk("async_rst_high", 32'(bus.high_bcd), 0);
      cycle();
      rst = 1'b0;
      repeat (3) cycle();
      chk("no_residual", 32'(bus.score_bin), 0);

      // POINTS=3 instance: second event during ADD
      bus3.game_start = 1'b1;
      cycle();
      bus3.game_start = 1'b0;
      bus3.reached_target = 1'b1;
      cycle();
      bus3.reached_target = 1'b0;
      chk("p3_busy_e0", 32'(bus3.busy), 1);
      busy_cnt = int'(bus3.busy);
      for (int k = 1; k <= 8; k++) begin
         bus3.reached_target = (k == 2);
         cycle();
         busy_cnt += int'(bus3.busy);
         chk("p3_score", 32'(bus3.score_bin), (k < 6) ? k : 6);
      end
      bus3.reached_target = 1'b0;
      chk("p3_busy_cycles", busy_cnt, 6);

      // random play
      start_pulse();
      repeat (3000) begin
         bus.reached_target = ($urandom_range(0, 99) < 45);
         bus.game_start     = ($urandom_range(0, 99) < 2);
         bus.game_over      = ($urandom_range(0, 99) < 2);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits on the score outputs.
REQ-002 Parameter MAX_SCORE, default 10: saturation score; SHALL satisfy MAX_SCORE <= 10^DIGITS-1.
REQ-003 Parameter POINTS, default 1: points credited per target event; SHALL be >= 1.
REQ-004 Parameter LEVEL_STEP, default 5: points per level; SHALL be >= 1.
REQ-005 Parameter PEND_W, default 4: width of the pending-points counter.
REQ-006 CLK  in  1  single clock; all state updates on its rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 REACHED_TARGET  in  1  level from snake logic; each rising edge is one target event.
REQ-009 GAME_START  in  1  synchronous, level-sampled: clear current game and enter play.
REQ-010 GAME_OVER  in  1  synchronous, level-sampled: freeze score.
REQ-011 SCORE_BIN  out  SW=clog2(MAX_SCORE+1)  current score, binary.
REQ-012 SCORE_BCD  out  4*DIGITS  current score, BCD; digit 0 in bits [3:0].
REQ-013 HIGH_BCD  out  4*DIGITS  highest score since RESET, BCD.
REQ-014 LEVEL  out  4  floor(score/LEVEL_STEP), saturating at 15.
REQ-015 LEVEL_UP  out  1  one-cycle pulse when LEVEL increments.
REQ-016 NEW_HIGH  out  1  sticky: current game has set a new high score.
REQ-017 MAX_REACHED  out  1  score equals MAX_SCORE.
REQ-018 BUSY  out  1  high while in state ADD.

Function
REQ-019 Edge detect: registered copy of REACHED_TARGET; event = REACHED_TARGET & ~prev, sampled at the clock edge.
REQ-020 FSM states: PLAY, ADD, OVER.
REQ-021 PLAY: an event SHALL load pending <= POINTS and move to ADD; the score does not change on that edge.
REQ-022 ADD: each clock SHALL increment score by 1 and decrement pending by 1; return to PLAY on the edge where pending goes 1 -> 0.
REQ-023 An event during ADD SHALL set pending <= pending - 1 + POINTS, saturating at 2^PEND_W-1; no event is lost below saturation.
REQ-024 When the score becomes MAX_SCORE: pending <= 0, MAX_REACHED <= 1, state <= OVER.
REQ-025 OVER: events SHALL be ignored; score, level and flags are held.
REQ-026 Input priority per edge is GAME_START > GAME_OVER > event.
REQ-027 GAME_START from any state: score, BCD, LEVEL, pending, NEW_HIGH and MAX_REACHED <= 0; state <= PLAY; HIGH_BCD retained.
REQ-028 GAME_OVER in PLAY or ADD: state <= OVER and pending discarded.
REQ-029 SCORE_BCD SHALL be updated incrementally alongside SCORE_BIN (digit 9 -> 0 with carry); no binary-to-BCD divider.
REQ-030 SCORE_BCD and SCORE_BIN SHALL always represent the same value.
REQ-031 High score: on any increment where the new score > high score, HIGH_BCD <= new score BCD and NEW_HIGH <= 1, on the same edge.
REQ-032 LEVEL: a sub-counter SHALL wrap at LEVEL_STEP; on each wrap LEVEL increments (saturating at 15) and LEVEL_UP pulses for exactly one cycle.
REQ-033 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-034 RESET asserted SHALL immediately clear all outputs, pending, prev and HIGH_BCD to 0 and set the state to PLAY, independent of CLK.
REQ-035 Deassertion mid-ADD SHALL leave no residual pending points.

Verification (defaults: DIGITS=2, MAX_SCORE=10, POINTS=1, LEVEL_STEP=5, PEND_W=4)
REQ-036 Single 1-cycle pulse on REACHED_TARGET -> BUSY high for 1 cycle; SCORE_BIN 0 -> 1 two edges after the pulse; SCORE_BCD=8'h01; NEW_HIGH=1.
REQ-037 REACHED_TARGET held high for 20 cycles -> exactly 1 point credited.
REQ-038 10 separate events -> SCORE_BCD=8'h10 and MAX_REACHED=1; state OVER; 11th event ignored; LEVEL_UP pulses at score 5 and at score 10; LEVEL=2.
REQ-039 POINTS=3, event, then a second event during ADD -> score rises by 1 per cycle to 6; BUSY high for 6 consecutive cycles.
REQ-040 Score 7 then GAME_START -> score 0 and HIGH_BCD=8'h07; then 3 points -> NEW_HIGH=0 and HIGH_BCD unchanged.
REQ-041 GAME_START and GAME_OVER high together -> PLAY; RESET pulsed mid-ADD without a clock edge -> all outputs 0 at once.
